// File: rtl/regs_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : regs_wb_ctrl
//  Purpose  : Write-back controller for the register file. It arbitrates
//             between the single-cycle ALU result path and the multi-cycle
//             mul/div result path, then drives one registered write per cycle
//             into the register file. It also keeps a per-register count of
//             outstanding writes, so ID can stall on operands that are not
//             yet committed.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst              clock (rising edge); asynchronous active-high reset
//    iss_valid/iss_waddr   ID issues an instruction that will write iss_waddr
//    iss_ready             issue accepted (combinational)
//    alu_valid/waddr/wdata ALU result; alu_ready = accepted this cycle
//    md_valid/waddr/wdata  mul/div result; md_ready = accepted this cycle
//    raddr1..3             ID operand addresses
//    busy1..3              operand has an outstanding write (combinational)
//    we/waddr/wdata        registered register-file write port
// ============================================================================
module regs_wb_ctrl #(
  parameter int CNT_W        = 2,  // width of each outstanding-write counter
  parameter int STARVE_LIMIT = 4   // MD losses tolerated before MD is forced
) (
  input  logic        clk,
  input  logic        rst,
  // issue side
  input  logic        iss_valid,
  input  logic [4:0]  iss_waddr,
  output logic        iss_ready,
  // ALU result path
  input  logic        alu_valid,
  input  logic [4:0]  alu_waddr,
  input  logic [31:0] alu_wdata,
  output logic        alu_ready,
  // mul/div result path
  input  logic        md_valid,
  input  logic [4:0]  md_waddr,
  input  logic [31:0] md_wdata,
  output logic        md_ready,
  // operand busy queries
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic [4:0]  raddr3,
  output logic        busy1,
  output logic        busy2,
  output logic        busy3,
  // register-file write port
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata
);

  localparam int NREG = 32;
  // Starve counter only needs to reach STARVE_LIMIT.
  localparam int SW   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] c_cnt_max    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
  localparam logic [SW-1:0]    c_starve_lim = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0]    c_starve_one = SW'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt [NREG];   // entry 0 never changes from 0
  logic [SW-1:0]    r_starve;
  logic             r_we;
  logic [4:0]       r_waddr;
  logic [31:0]      r_wdata;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic             w_md_force;
  logic             w_accept;
  logic [4:0]       w_acc_addr;
  logic [31:0]      w_acc_data;
  logic             w_iss_fire;
  logic [NREG-1:0]  w_inc;
  logic [NREG-1:0]  w_dec;

  // --------------------------------------------------------------------------
  // Arbitration: ALU has default priority. Once MD has lost STARVE_LIMIT
  // consecutive cycles it is forced through and the ALU is held off.
  // Gating with md_valid keeps a stale count from blocking the ALU.
  // --------------------------------------------------------------------------
  assign w_md_force = md_valid && (r_starve == c_starve_lim);
  assign alu_ready  = alu_valid && !w_md_force;
  assign md_ready   = md_valid && (!alu_valid || w_md_force);

  assign w_accept   = alu_ready || md_ready;
  assign w_acc_addr = md_ready ? md_waddr : alu_waddr;
  assign w_acc_data = md_ready ? md_wdata : alu_wdata;

  // --------------------------------------------------------------------------
  // Issue acceptance: a register whose counter is full cannot take another
  // outstanding write. Register 0 is never tracked and is always ready.
  // --------------------------------------------------------------------------
  assign iss_ready  = (iss_waddr == 5'd0) || (r_cnt[iss_waddr] != c_cnt_max);
  assign w_iss_fire = iss_valid && iss_ready && (iss_waddr != 5'd0);

  // --------------------------------------------------------------------------
  // Per-register increment/decrement requests. A commit is the registered
  // write being presented this cycle, so the count drops at the end of the
  // commit cycle and busy stays high while the register file writes through.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
      if (gi == 0) begin : g_r0
        assign w_inc[gi] = 1'b0;
        assign w_dec[gi] = 1'b0;
      end else begin : g_rn
        assign w_inc[gi] = w_iss_fire && (iss_waddr == 5'(gi));
        assign w_dec[gi] = r_we && (r_waddr == 5'(gi));
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outstanding-write counters. Simultaneous issue and commit to the same
  // register cancel. A commit with a zero count is a producer protocol
  // error; the counter holds at zero rather than wrapping.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + c_cnt_one;
        end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - c_cnt_one;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Starvation counter: counts consecutive cycles MD is valid but refused.
  // It cannot exceed the limit because reaching it forces MD to win.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (md_valid && !md_ready) begin
      if (r_starve != c_starve_lim) begin
        r_starve <= r_starve + c_starve_one;
      end
    end else begin
      r_starve <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Registered write port. Results to register 0 are accepted normally but
  // never raise we. Address/data hold when nothing is accepted.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_accept && (w_acc_addr != 5'd0);
      if (w_accept) begin
        r_waddr <= w_acc_addr;
        r_wdata <= w_acc_data;
      end
    end
  end

  assign we    = r_we;
  assign waddr = r_waddr;
  assign wdata = r_wdata;

  // --------------------------------------------------------------------------
  // Busy query on current state. Bypass on a commit cycle is decided in ID.
  // --------------------------------------------------------------------------
  assign busy1 = (r_cnt[raddr1] != '0);
  assign busy2 = (r_cnt[raddr2] != '0);
  assign busy3 = (r_cnt[raddr3] != '0);

endmodule
`default_nettype wire

// File: tb/tb_regs_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regs_wb_ctrl
//  Purpose  : Self-checking bench for regs_wb_ctrl. A behavioural model
//             (integer counts per register, starvation counter, pending
//             commit) predicts every handshake and write; directed scenarios
//             are followed by randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regs_wb_ctrl;

  localparam int CNT_W        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_waddr;
  logic        iss_ready;
  logic        alu_valid;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        alu_ready;
  logic        md_valid;
  logic [4:0]  md_waddr;
  logic [31:0] md_wdata;
  logic        md_ready;
  logic [4:0]  raddr1, raddr2, raddr3;
  logic        busy1, busy2, busy3;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  always #5 clk = ~clk;

  regs_wb_ctrl #(.CNT_W(CNT_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_waddr(iss_waddr), .iss_ready(iss_ready),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .alu_ready(alu_ready),
    .md_valid(md_valid), .md_waddr(md_waddr), .md_wdata(md_wdata),
    .md_ready(md_ready),
    .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3),
    .busy1(busy1), .busy2(busy2), .busy3(busy3),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_cnt [32];
  int          m_starve;
  bit          m_we;
  int          m_waddr;
  logic [31:0] m_wdata;
  bit          e_iss_ready, e_alu_ready, e_md_ready;

  // observed values of the latest cycle
  logic ob_iss_ready, ob_alu_ready, ob_md_ready;
  logic ob_busy1, ob_busy2, ob_busy3, ob_we;
  logic [4:0]  ob_waddr;
  logic [31:0] ob_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_starve = 0;
    m_we     = 1'b0;
    m_waddr  = 0;
    m_wdata  = '0;
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_waddr = '0;
    alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
    md_valid  = 1'b0; md_waddr  = '0; md_wdata  = '0;
  endtask

  // Called just after a falling edge with inputs applied. Checks the
  // combinational outputs, advances through the rising edge, updates the
  // model, checks the write port, and returns at the next falling edge.
  task automatic cycle();
    bit          forced;
    int          r;
    bit          acc;
    int          a_addr;
    logic [31:0] a_data;
    #1;
    e_iss_ready = (iss_waddr == 0) || (m_cnt[iss_waddr] < CNT_MAX);
    forced      = md_valid && (m_starve >= STARVE_LIMIT);
    e_alu_ready = alu_valid && !forced;
    e_md_ready  = md_valid && (forced || !alu_valid);
    ob_iss_ready = iss_ready; ob_alu_ready = alu_ready; ob_md_ready = md_ready;
    ob_busy1 = busy1; ob_busy2 = busy2; ob_busy3 = busy3;
    chk("iss_ready", iss_ready, e_iss_ready);
    chk("alu_ready", alu_ready, e_alu_ready);
    chk("md_ready",  md_ready,  e_md_ready);
    chk("busy1", busy1, m_cnt[raddr1] != 0);
    chk("busy2", busy2, m_cnt[raddr2] != 0);
    chk("busy3", busy3, m_cnt[raddr3] != 0);
    @(posedge clk);
    // scoreboard: issue adds, the commit presented this cycle removes
    if (iss_valid && e_iss_ready && iss_waddr != 0) m_cnt[iss_waddr] += 1;
    if (m_we) begin
      r = m_waddr;
      if (m_cnt[r] > 0) m_cnt[r] -= 1;
    end
    if (md_valid && !e_md_ready) m_starve += 1;
    else                         m_starve = 0;
    acc    = e_alu_ready || e_md_ready;
    a_addr = e_md_ready ? int'(md_waddr) : int'(alu_waddr);
    a_data = e_md_ready ? md_wdata : alu_wdata;
    m_we   = acc && (a_addr != 0);
    if (acc) begin
      m_waddr = a_addr;
      m_wdata = a_data;
    end
    #1;
    ob_we = we; ob_waddr = waddr; ob_wdata = wdata;
    chk("we", we, m_we);
    if (m_we) begin
      chk("waddr", waddr, m_waddr);
      chk("wdata", wdata, m_wdata);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy1", busy1, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int pend [$];
  bit alu_hold, md_hold;
  int idx;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    raddr1 = 5'd0; raddr2 = 5'd0; raddr3 = 5'd0;
    model_reset();
    @(negedge clk);
    do_reset();

    // ---- single ALU write to r3 ----
    raddr1 = 5'd3;
    iss_valid = 1'b1; iss_waddr = 5'd3;
    cycle();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'hDEADBEEF;
    cycle();
    chk("alu3_ready", ob_alu_ready, 1);
    chk("alu3_we", ob_we, 1);
    chk("alu3_waddr", ob_waddr, 3);
    chk("alu3_wdata", ob_wdata, 32'hDEADBEEF);
    alu_valid = 1'b0;
    cycle();                         // commit cycle still busy
    chk("alu3_busy_commit", ob_busy1, 1);
    cycle();
    chk("alu3_busy_after", ob_busy1, 0);

    // ---- contention and starvation ----
    do_reset();
    alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'h1111;
    md_valid  = 1'b1; md_waddr  = 5'd0; md_wdata  = 32'h2222;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk($sformatf("starve_alu%0d", k), ob_alu_ready, (k == 4) ? 0 : 1);
      chk($sformatf("starve_md%0d", k),  ob_md_ready,  (k == 4) ? 1 : 0);
    end
    idle_inputs();

    // ---- counter saturation on r7 ----
    do_reset();
    iss_valid = 1'b1; iss_waddr = 5'd7;
    for (int k = 0; k < 3; k++) cycle();
    cycle();
    chk("sat_full", ob_iss_ready, 0);
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_waddr = 5'd7; alu_wdata = 32'h77;
    cycle();
    alu_valid = 1'b0;
    cycle();                         // commit cycle: count still 3
    chk("sat_commit_cycle", ob_iss_ready, 0);
    cycle();
    chk("sat_recovered", ob_iss_ready, 1);

    // ---- simultaneous issue and commit to r9, then r0 traffic ----
    do_reset();
    raddr1 = 5'd9;
    iss_valid = 1'b1; iss_waddr = 5'd9;
    cycle();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_waddr = 5'd9; alu_wdata = 32'h9999;
    cycle();
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_waddr = 5'd9;    // coincides with the commit
    cycle();
    iss_valid = 1'b0;
    cycle();
    chk("r9_busy", ob_busy1, 1);
    raddr1 = 5'd0;
    iss_valid = 1'b1; iss_waddr = 5'd0;
    cycle();
    chk("r0_iss_ready", ob_iss_ready, 1);
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'hFFFFFFFF;
    cycle();
    chk("r0_alu_ready", ob_alu_ready, 1);
    chk("r0_we", ob_we, 0);
    alu_valid = 1'b0;
    cycle();
    chk("r0_busy", ob_busy1, 0);

    // ---- busy ports on r12 ----
    do_reset();
    raddr1 = 5'd12; raddr2 = 5'd12; raddr3 = 5'd12;
    iss_valid = 1'b1; iss_waddr = 5'd12;
    cycle();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_waddr = 5'd12; alu_wdata = 32'hC0C0;
    cycle();
    chk("b12_busy1", ob_busy1, 1);
    chk("b12_busy2", ob_busy2, 1);
    chk("b12_busy3", ob_busy3, 1);
    alu_valid = 1'b0;
    cycle();
    cycle();
    chk("b12_clr1", ob_busy1, 0);
    chk("b12_clr2", ob_busy2, 0);
    chk("b12_clr3", ob_busy3, 0);

    // ---- reset in the middle of a write ----
    do_reset();
    raddr1 = 5'd5;
    iss_valid = 1'b1; iss_waddr = 5'd5;
    cycle();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'h1234;
    cycle();
    chk("mid_we_before", ob_we, 1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_we", we, 0);
    chk("mid_busy5", busy1, 0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    iss_valid = 1'b1; iss_waddr = 5'd5;
    alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'h1;
    md_valid  = 1'b1; md_waddr  = 5'd0; md_wdata  = 32'h2;
    cycle();
    chk("mid_iss_ready", ob_iss_ready, 1);
    chk("mid_alu_ready", ob_alu_ready, 1);
    idle_inputs();
    cycle();
    chk("mid_md_ready", ob_md_ready, 0);

    // ---- randomized traffic against the model ----
    do_reset();
    pend.delete();
    alu_hold = 1'b0; md_hold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!alu_hold && pend.size() > 0 && $urandom_range(0, 3) != 0) begin
        idx = $urandom_range(0, pend.size() - 1);
        alu_waddr = 5'(pend[idx]);
        alu_wdata = $urandom;
        pend.delete(idx);
        alu_hold = 1'b1;
      end
      if (!md_hold && pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, pend.size() - 1);
        md_waddr = 5'(pend[idx]);
        md_wdata = $urandom;
        pend.delete(idx);
        md_hold = 1'b1;
      end
      alu_valid = alu_hold;
      md_valid  = md_hold;
      iss_valid = 1'($urandom_range(0, 1));
      iss_waddr = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                               : 5'($urandom_range(0, 6));
      raddr1 = 5'($urandom_range(0, 7));
      raddr2 = 5'($urandom_range(0, 7));
      raddr3 = 5'($urandom_range(0, 31));
      cycle();
      if (alu_hold && e_alu_ready) alu_hold = 1'b0;
      if (md_hold && e_md_ready)   md_hold  = 1'b0;
      if (iss_valid && e_iss_ready) pend.push_back(int'(iss_waddr));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regs_wb_ctrl.md
Name: regs_wb_ctrl

Overview:
- Writer end of the register-file write port (we/waddr/wdata).
- Arbitrates results from the single-cycle ALU path and the multi-cycle mul/div path, then drives exactly one registered write per cycle into the register file.
- Holds a per-register outstanding-write scoreboard.
  - ID uses it to stall on operands whose producer has not yet committed.
  - Stalling on the scoreboard replaces relying on the register file's same-cycle bypass.

Parameters:
- CNT_W, 2, width of each per-register outstanding-write counter; max outstanding per register = 2^CNT_W-1.
- STARVE_LIMIT, 4, consecutive cycles md_valid may lose arbitration before MD is forced to win.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- iss_valid  in  1  ID issues an instruction that will write iss_waddr
- iss_waddr  in  5  destination register of issued instruction
- iss_ready  out  1  issue accepted (combinational)
- alu_valid  in  1  ALU result available
- alu_waddr  in  5  ALU destination
- alu_wdata  in  32  ALU result
- alu_ready  out  1  ALU result accepted this cycle (combinational)
- md_valid  in  1  mul/div result available
- md_waddr  in  5  mul/div destination
- md_wdata  in  32  mul/div result
- md_ready  out  1  mul/div result accepted this cycle (combinational)
- raddr1, raddr2, raddr3  in  5 each  ID operand addresses
- busy1, busy2, busy3  out  1 each  operand has outstanding write (combinational)
- we  out  1  register-file write enable (registered)
- waddr  out  5  register-file write address (registered)
- wdata  out  32  register-file write data (registered)

Behaviour:
- Reset (async, rst=1):
  - we=0, waddr=0, wdata=0.
  - All counters cleared, starve counter cleared.
  - busyN=0.
  - Any in-flight handshake is discarded.
- Arbitration, one winner per cycle:
  - Default priority: ALU over MD.
  - starve_cnt increments each cycle md_valid=1 and md_ready=0; it clears when MD is accepted or md_valid=0.
  - When starve_cnt==STARVE_LIMIT, MD wins and ALU is held (alu_ready=0).
  - With only one source valid, that source wins.
  - The ready of the losing source is 0; its producer holds valid/addr/data stable until ready.
- Commit latency:
  - Accepted result appears on we/waddr/wdata on the next rising edge, exactly 1 cycle.
  - we=1 for one cycle per accepted result.
  - No accept in a cycle gives we=0 next cycle; waddr/wdata hold their last value.
- Writes to register 0:
  - Accepted and handshaked normally.
  - Produce we=0 and no scoreboard change.
- Scoreboard (cnt[1..31], cnt[0] constant 0):
  - Issue handshake (iss_valid & iss_ready, iss_waddr!=0) increments cnt[iss_waddr].
  - A commit (registered we=1) decrements cnt[waddr].
  - Issue and commit to the same register in the same cycle leaves the count unchanged.
  - iss_ready=0 iff iss_waddr!=0 and cnt[iss_waddr] is at max (2^CNT_W-1).
  - An issue to register 0 is always ready.
  - A commit to a register whose cnt is 0 is a protocol error; the count saturates at 0 and never wraps.
- Busy query:
  - busyN = (cnt[raddrN]!=0), purely combinational on current state.
  - A commit cycle (we=1) still shows busy, because the count drops at the end of that cycle.
  - In that cycle the register file's write-through supplies the data, so ID may treat the operand as available when we & waddr==raddrN.
  - This block exposes busy only; the bypass decision lives in ID.
- Results must be preceded by a matching issue; ordering between issue and result is the producer's responsibility.

Test Plan:
- Reset mid-operation: issue r5, ALU result r5=0x1234 accepted, assert rst before the next edge -> we=0, busy for r5=0, all readies recover after rst drops.
- Single ALU write: issue r3, next cycle alu_valid r3=0xDEADBEEF -> alu_ready=1; next cycle we=1, waddr=3, wdata=0xDEADBEEF; the cycle after, busy for r3=0.
- Contention and starvation (STARVE_LIMIT=4): alu_valid and md_valid held high continuously -> ALU wins 4 cycles, MD wins the 5th (md_ready=1, alu_ready=0), starve_cnt clears, ALU wins again.
- Counter saturation (CNT_W=2): issue r7 three times with no results -> cnt=3, fourth issue sees iss_ready=0; one commit to r7 -> iss_ready=1 the following cycle.
- Simultaneous issue and commit to r9 at cnt=1 -> cnt stays 1, busy for r9 stays 1; r0 issue and ALU result r0=0xFFFFFFFF -> handshakes complete, we=0, no busy.
- Busy ports: raddr1=raddr2=raddr3=12 with one outstanding write to r12 -> busy1=busy2=busy3=1; after commit -> all 0.
